uvmt_cv32e40s_obi_bounded_responder: RTL and testbench

// - OBI responder (memory-side) model for the cv32e40s instr or data bus in formal and simulation benches.
// - Accepts address phases, stores writes, returns in-order responses through a bounded outstanding FIFO.
// - Grant and response stalls come from free inputs (tool-driven or random), capped so no stall exceeds a limit.
// - Checkers on the initiator side can then rely on bounded latency by construction.

---
 rtl/uvmt_cv32e40s_obi_bounded_responder_pkg.sv | 24 ++
 rtl/uvmt_cv32e40s_obi_bounded_responder_if.sv | 32 +++
 rtl/uvmt_cv32e40s_obi_bounded_responder_rsp_fifo.sv | 49 ++++
 rtl/uvmt_cv32e40s_obi_bounded_responder.sv | 99 +++++++++
 tb/tb_uvmt_cv32e40s_obi_bounded_responder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uvmt_cv32e40s_obi_bounded_responder_pkg.sv
// Shared types and defaults for the bounded OBI responder model.
package uvmt_cv32e40s_obi_responder_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_entry_t;

  localparam int unsigned DEF_MAX_GNT_STALLS  = 8;
  localparam int unsigned DEF_MAX_RSP_STALLS  = 8;
  localparam int unsigned DEF_MAX_OUTSTANDING = 2;
  localparam int unsigned DEF_MEM_WORDS       = 16;

  function automatic logic [31:0] apply_be(logic [31:0] old_word, logic [31:0] wdata,
                                           logic [3:0] be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_obi_bounded_responder_if.sv
// OBI bus plus stall-control bundle between an initiator and the bounded responder.
interface uvmt_cv32e40s_obi_bounded_responder_if
  import uvmt_cv32e40s_obi_responder_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic             req_i;
  logic             gnt_o;
  logic [31:0]      addr_i;
  logic             we_i;
  logic [3:0]       be_i;
  logic [31:0]      wdata_i;
  logic             rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             gnt_stall_i;
  logic             rsp_stall_i;
  logic [CNT_W-1:0] outstanding_o;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, gnt_stall_i, rsp_stall_i,
    output gnt_o, rvalid_o, rdata_o, err_o, outstanding_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, gnt_stall_i, rsp_stall_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, outstanding_o
  );

endinterface

// File: rtl/uvmt_cv32e40s_obi_bounded_responder_rsp_fifo.sv
// In-order response FIFO; power-of-two depth so pointers wrap naturally.
module uvmt_cv32e40s_obi_rsp_fifo
  import uvmt_cv32e40s_obi_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  obi_rsp_entry_t   entry,
  input  logic             pop,
  output obi_rsp_entry_t   head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  obi_rsp_entry_t   store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = store[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (push) store[wr_ptr] <= entry;
  end

endmodule

// File: rtl/uvmt_cv32e40s_obi_bounded_responder.sv
// Bounded-latency OBI responder: byte-enabled memory, capped grant/response stalls.
// Optional macro OBI_RESP_ERR_EN flags (and suppresses) accesses above the memory window.
module uvmt_cv32e40s_obi_bounded_responder
  import uvmt_cv32e40s_obi_responder_pkg::*;
#(
  parameter int unsigned MAX_GNT_STALLS  = DEF_MAX_GNT_STALLS,
  parameter int unsigned MAX_RSP_STALLS  = DEF_MAX_RSP_STALLS,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned MEM_WORDS       = DEF_MEM_WORDS
) (
  input logic clk_i,
  input logic rst_ni,
  uvmt_cv32e40s_obi_bounded_responder_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned GCNT_W = $clog2(MAX_GNT_STALLS + 1);
  localparam int unsigned RCNT_W = $clog2(MAX_RSP_STALLS + 1);

  logic [31:0]       mem [MEM_WORDS];
  logic [GCNT_W-1:0] gnt_cnt;
  logic [RCNT_W-1:0] rsp_cnt;
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic              unused_addr;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  obi_rsp_entry_t    push_entry;
  obi_rsp_entry_t    head;

  assign idx = bus.addr_i[2 +: IDX_W];

`ifdef OBI_RESP_ERR_EN
  assign addr_err    = |bus.addr_i[31:2+IDX_W];
  assign unused_addr = ^bus.addr_i[1:0];
`else
  assign addr_err    = 1'b0;
  assign unused_addr = ^{bus.addr_i[31:2+IDX_W], bus.addr_i[1:0]};
`endif

  // Grant ignores a same-cycle pop: fullness is judged on the registered count.
  assign bus.gnt_o = rst_ni & bus.req_i & !fifo_full &
                     (!bus.gnt_stall_i | (gnt_cnt == GCNT_W'(MAX_GNT_STALLS)));
  assign accept    = bus.req_i & bus.gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_cnt <= '0;
    end else if (bus.req_i && !bus.gnt_o && !fifo_full) begin
      if (gnt_cnt != GCNT_W'(MAX_GNT_STALLS)) gnt_cnt <= gnt_cnt + 1'b1;
    end else begin
      gnt_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
    end else if (accept && bus.we_i && !addr_err) begin
      mem[idx] <= apply_be(mem[idx], bus.wdata_i, bus.be_i);
    end
  end

  // Reads capture the pre-edge word; a preceding back-to-back write has already landed.
  always_comb begin
    push_entry.err   = addr_err;
    push_entry.rdata = (bus.we_i || addr_err) ? 32'h0 : mem[idx];
  end

  uvmt_cv32e40s_obi_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept),
    .entry  (push_entry),
    .pop    (bus.rvalid_o),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (bus.outstanding_o)
  );

  assign bus.rvalid_o = !fifo_empty &
                        (!bus.rsp_stall_i | (rsp_cnt == RCNT_W'(MAX_RSP_STALLS)));
  assign bus.rdata_o  = bus.rvalid_o ? head.rdata : 32'h0;
  assign bus.err_o    = bus.rvalid_o & head.err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_cnt <= '0;
    end else if (!fifo_empty && !bus.rvalid_o) begin
      if (rsp_cnt != RCNT_W'(MAX_RSP_STALLS)) rsp_cnt <= rsp_cnt + 1'b1;
    end else begin
      rsp_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_bounded_responder.sv
// Scoreboard bench for the bounded OBI responder (default parameters).
module tb_uvmt_cv32e40s_obi_bounded_responder;
  import uvmt_cv32e40s_obi_responder_pkg::*;

`ifdef OBI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [1:0] gs_mode;
  logic [1:0] rs_mode;
  logic rnd_g;
  logic rnd_r;

  int n_cmp = 0;
  int n_mis = 0;
  int rsp_seen = 0;
  obi_rsp_entry_t exp_q[$];
  logic [31:0] model_mem [16];

  uvmt_cv32e40s_obi_bounded_responder_if #(.MAX_OUTSTANDING(2)) bus ();

  uvmt_cv32e40s_obi_bounded_responder #(
    .MAX_GNT_STALLS  (8),
    .MAX_RSP_STALLS  (8),
    .MAX_OUTSTANDING (2),
    .MEM_WORDS       (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  assign bus.gnt_stall_i = (gs_mode == 2'd2) ? rnd_g : gs_mode[0];
  assign bus.rsp_stall_i = (rs_mode == 2'd2) ? rnd_r : rs_mode[0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rnd_g = 1'b0;
    rnd_r = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_g = 1'($urandom_range(0, 1));
      rnd_r = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every response is compared against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rvalid_o) begin
      obi_rsp_entry_t e;
      rsp_seen++;
      check_val("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("rsp_rdata", 64'(bus.rdata_o), 64'(e.rdata));
        check_val("rsp_err", 64'(bus.err_o), 64'(e.err));
      end
    end
  end

  task automatic model_accept(input logic [31:0] a, input logic w, input logic [3:0] b,
                              input logic [31:0] d);
    obi_rsp_entry_t e;
    logic [3:0] i;
    logic err;
    i = a[5:2];
    err = ERR_EN && (a[31:6] != 26'd0);
    e.err = err;
    e.rdata = 32'h0;
    if (w) begin
      if (!err) begin
        for (int k = 0; k < 4; k++) begin
          if (b[k]) model_mem[i][8*k +: 8] = d[8*k +: 8];
        end
      end
    end else if (!err) begin
      e.rdata = model_mem[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 16; k++) model_mem[k] = 32'h0;
  endtask

  // Called just after a posedge; returns just after the accepting posedge with req still high.
  task automatic obi_access(input logic [31:0] a, input logic w, input logic [3:0] b,
                            input logic [31:0] d);
    int n;
    n = 0;
    bus.req_i = 1'b1;
    bus.addr_i = a;
    bus.we_i = w;
    bus.be_i = b;
    bus.wdata_i = d;
    while (n < 200) begin
      @(negedge clk);
      if (bus.gnt_o) break;
      n++;
    end
    if (!bus.gnt_o) begin
      check_val("gnt_timeout", 64'(bus.gnt_o), 64'd1);
      bus.req_i = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(a, w, b, d);
    #1;
  endtask

  task automatic go_idle();
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check_val("drain_outstanding", 64'(bus.outstanding_o), 64'd0);
    check_val("idle_rdata", 64'(bus.rdata_o), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd_addr [3];
  int rsp_cyc [3];
  int nacc;
  int nrsp;
  int max_out;
  int seen_snap;
  int n;
  logic acc;

  initial begin
    rst_n = 1'b0;
    gs_mode = 2'd0;
    rs_mode = 2'd0;
    bus.req_i = 1'b0;
    bus.addr_i = 32'h0;
    bus.we_i = 1'b0;
    bus.be_i = 4'h0;
    bus.wdata_i = 32'h0;
    clear_model();

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_gnt", 64'(bus.gnt_o), 64'd0);
    check_val("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
    check_val("rst_rdata", 64'(bus.rdata_o), 64'd0);
    check_val("rst_err", 64'(bus.err_o), 64'd0);
    check_val("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
    rst_n = 1'b1;

    // Grant capped after 8 stalled cycles, response one cycle later
    gs_mode = 2'd1;
    @(posedge clk);
    #1;
    bus.req_i = 1'b1;
    bus.addr_i = 32'h0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.gnt_o) break;
      n++;
    end
    check_val("gnt_stall_latency", 64'(n), 64'd8);
    @(posedge clk);
    model_accept(32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    go_idle();
    gs_mode = 2'd0;
    @(negedge clk);
    check_val("rsp_next_cycle", 64'(bus.rvalid_o), 64'd1);
    drain();

    // Byte-enabled write, back-to-back read of the same word
    obi_access(32'h8, 1'b1, 4'b0101, 32'hDEADBEEF);
    obi_access(32'h8, 1'b0, 4'hF, 32'h0);
    obi_access(32'hC, 1'b1, 4'hF, 32'h13579BDF);
    obi_access(32'h4, 1'b1, 4'b1000, 32'hA5FFFFFF);
    go_idle();
    drain();

    // Full FIFO under constant response stall: grant blocking and response spacing
    rs_mode = 2'd1;
    rd_addr[0] = 32'h8;
    rd_addr[1] = 32'h4;
    rd_addr[2] = 32'hC;
    nacc = 0;
    nrsp = 0;
    max_out = 0;
    for (int k = 0; k < 3; k++) rsp_cyc[k] = -1;
    @(posedge clk);
    #1;
    bus.req_i = 1'b1;
    bus.we_i = 1'b0;
    bus.addr_i = rd_addr[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (int'(bus.outstanding_o) > max_out) max_out = int'(bus.outstanding_o);
      if (c == 2) begin
        check_val("full_gnt_low", 64'(bus.gnt_o), 64'd0);
        check_val("full_outstanding", 64'(bus.outstanding_o), 64'd2);
      end
      if (c == 9) begin
        check_val("pop_cycle_rvalid", 64'(bus.rvalid_o), 64'd1);
        check_val("pop_cycle_gnt_low", 64'(bus.gnt_o), 64'd0);
        check_val("pop_cycle_outstanding", 64'(bus.outstanding_o), 64'd2);
      end
      if (c == 10) check_val("after_pop_gnt", 64'(bus.gnt_o), 64'd1);
      if (c == 11) check_val("refill_outstanding", 64'(bus.outstanding_o), 64'd2);
      if (bus.rvalid_o && nrsp < 3) begin
        rsp_cyc[nrsp] = c;
        nrsp++;
      end
      acc = bus.req_i && bus.gnt_o;
      @(posedge clk);
      if (acc) begin
        model_accept(bus.addr_i, 1'b0, 4'h0, 32'h0);
        nacc++;
      end
      #1;
      if (acc) begin
        if (nacc < 3) bus.addr_i = rd_addr[nacc];
        else bus.req_i = 1'b0;
      end
    end
    check_val("rsp_spacing_0", 64'(rsp_cyc[0]), 64'd9);
    check_val("rsp_spacing_1", 64'(rsp_cyc[1]), 64'd18);
    check_val("rsp_spacing_2", 64'(rsp_cyc[2]), 64'd27);
    check_val("outstanding_max", 64'(max_out), 64'd2);
    rs_mode = 2'd0;
    drain();

    // Reset with two responses in flight
    rs_mode = 2'd1;
    obi_access(32'h8, 1'b0, 4'hF, 32'h0);
    obi_access(32'hC, 1'b0, 4'hF, 32'h0);
    go_idle();
    @(negedge clk);
    check_val("pre_rst_outstanding", 64'(bus.outstanding_o), 64'd2);
    @(posedge clk);
    #1;
    bus.req_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_rvalid", 64'(bus.rvalid_o), 64'd0);
    check_val("midrst_outstanding", 64'(bus.outstanding_o), 64'd0);
    check_val("midrst_gnt", 64'(bus.gnt_o), 64'd0);
    bus.req_i = 1'b0;
    exp_q.delete();
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rs_mode = 2'd0;
    seen_snap = rsp_seen;
    repeat (20) @(negedge clk);
    check_val("post_rst_no_rsp", 64'(rsp_seen - seen_snap), 64'd0);
    @(posedge clk);
    #1;
    obi_access(32'h8, 1'b0, 4'hF, 32'h0);
    go_idle();
    drain();

    // Upper address bits: error response or aliasing depending on build
    obi_access(32'h0, 1'b1, 4'hF, 32'h12345678);
    obi_access(32'h104, 1'b1, 4'hF, 32'hCAFEF00D);
    obi_access(32'h100, 1'b0, 4'hF, 32'h0);
    obi_access(32'h4, 1'b0, 4'hF, 32'h0);
    go_idle();
    drain();

    // Random traffic with random capped stalls
    gs_mode = 2'd2;
    rs_mode = 2'd2;
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = ($urandom & 32'h3C) | (($urandom_range(0, 7) == 0) ? 32'h400 : 32'h0);
      obi_access(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    go_idle();
    gs_mode = 2'd0;
    rs_mode = 2'd0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
